// File: rtl/uart_rx_fifo_pkg.sv
// Shared encodings for the UART receiver: parity modes, deserialiser states,
// error-flag bit positions and the parity check helper.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;
   localparam logic [1:0] PAR_MARK = 2'b11;

   localparam int ERR_PARITY = 0;
   localparam int ERR_FRAME  = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } rx_state_t;

   // data_xor is the XOR of all payload bits; pbit is the received parity bit.
   function automatic logic parity_err(input logic [1:0] mode, input logic data_xor,
                                       input logic pbit);
      case (mode)
         PAR_ODD:  return !(data_xor ^ pbit);
         PAR_EVEN: return data_xor ^ pbit;
         PAR_MARK: return !pbit;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with registered storage and a valid/ready read side.
// A push while full is accepted only when the head is popped in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   input  logic             ready,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             pop;
   logic             wr_en;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign valid = !empty;
   assign dout  = mem[rd_ptr];
   assign pop   = valid & ready;
   assign wr_en = push & (!full | pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing and an output FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | start bit; a high mid-bit sample aborts as a false start
// DATA   | shifting payload bits, LSB first
// PARITY | checking the parity bit against the latched mode
// STOP1  | first stop bit; pushes at mid-bit unless two stop bits are latched
// STOP2  | second stop bit; pushes at mid-bit
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BODE_RATE  = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic [1:0]           rx_ctrl,
   input  logic                 rx_stop2,
   output logic [DATA_BITS-1:0] rx_data,
   output logic [1:0]           rx_err,
   output logic                 rx_data_valid,
   input  logic                 rx_ready,
   output logic                 rx_overrun,
   input  logic                 rx_overrun_clr,
   output logic                 rx_busy
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BODE_RATE;
   localparam int MID          = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int BW           = $clog2(DATA_BITS);
   localparam int WIDTH        = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int SAMPLE_AT    = MID + 1;
`else
   localparam int SAMPLE_AT    = MID;
`endif

   rx_state_t            state;
   logic                 rx_meta, rx_s, rx_s_d;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           ctrl_l;
   logic                 stop2_l;
   logic                 perr, ferr;
   logic                 bit_val, sample, bit_end, push, frame_ferr;
   logic [WIDTH-1:0]     entry, head;
   logic                 fifo_full, fifo_empty;

`ifdef UART_RX_MAJORITY_EN
   logic rx_s_dd;
   // rx_s_dd, rx_s_d, rx_s hold the line at mid-1, mid, mid+1 when cnt == mid+1
   assign bit_val = (rx_s_dd & rx_s_d) | (rx_s_dd & rx_s) | (rx_s_d & rx_s);
   always_ff @(posedge clk) begin
      if (rst) rx_s_dd <= 1'b1;
      else     rx_s_dd <= rx_s_d;
   end
`else
   assign bit_val = rx_s;
`endif

   assign sample     = (cnt == CW'(SAMPLE_AT));
   assign bit_end    = (cnt == CW'(CLKS_PER_BIT - 1));
   assign frame_ferr = ferr | !bit_val;
   assign push       = sample && ((state == ST_STOP2) || (state == ST_STOP1 && !stop2_l));
   assign rx_busy    = (state != ST_IDLE);

   always_comb begin
      entry                         = '0;
      entry[DATA_BITS-1:0]          = shreg;
      entry[DATA_BITS + ERR_PARITY] = perr;
      entry[DATA_BITS + ERR_FRAME]  = frame_ferr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         ctrl_l  <= PAR_NONE;
         stop2_l <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
         cnt     <= bit_end ? '0 : cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (rx_s_d && !rx_s) state <= ST_START;
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  ctrl_l  <= rx_ctrl;
                  stop2_l <= rx_stop2;
                  bit_idx <= '0;
                  perr    <= 1'b0;
                  ferr    <= 1'b0;
               end
               // the false-start abort must win if sample and bit end coincide
               if (sample && bit_val) state <= ST_IDLE;
            end
            ST_DATA: begin
               if (sample) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_idx == BW'(DATA_BITS - 1))
                     state <= (ctrl_l != PAR_NONE) ? ST_PARITY : ST_STOP1;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end
            end
            ST_PARITY: begin
               if (sample) perr <= parity_err(ctrl_l, ^shreg, bit_val);
               if (bit_end) state <= ST_STOP1;
            end
            ST_STOP1: begin
               if (sample) ferr <= frame_ferr;
               if (bit_end && stop2_l) state <= ST_STOP2;
               if (sample && !stop2_l) state <= ST_IDLE;
            end
            ST_STOP2: begin
               if (sample) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rx_overrun <= 1'b0;
      else if (push && fifo_full && !(!fifo_empty && rx_ready))
         rx_overrun <= 1'b1;
      else if (rx_overrun_clr)
         rx_overrun <= 1'b0;
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (entry),
      .dout  (head),
      .valid (rx_data_valid),
      .ready (rx_ready),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_data = head[DATA_BITS-1:0];
   assign rx_err  = head[WIDTH-1:DATA_BITS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 10 clocks per bit; a queue model
// of expected FIFO entries is compared against the head on every valid cycle.
module tb_uart_rx_fifo;
   localparam int DB    = 8;
   localparam int DEPTH = 4;
   localparam int BIT   = 10;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 100;
`else
   localparam int LAT = 99;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx = 1'b1;
   logic [1:0]    rx_ctrl = 2'b00;
   logic          rx_stop2 = 1'b0;
   logic          rx_ready = 1'b1;
   logic          rx_overrun_clr = 1'b0;
   logic [DB-1:0] rx_data;
   logic [1:0]    rx_err;
   logic          rx_data_valid, rx_overrun, rx_busy;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         pops = 0;
   int         frame_start = 0;
   int         valid_rise = -1;
   int         p0;
   logic       prev_valid = 1'b0;
   logic       exp_ovr = 1'b0;
   logic [9:0] exp_q[$];
   logic [9:0] last_pop = '0;

   uart_rx_fifo #(
      .CLK_FREQ   (100_000_000),
      .BODE_RATE  (10_000_000),
      .DATA_BITS  (DB),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx             (rx),
      .rx_ctrl        (rx_ctrl),
      .rx_stop2       (rx_stop2),
      .rx_data        (rx_data),
      .rx_err         (rx_err),
      .rx_data_valid  (rx_data_valid),
      .rx_ready       (rx_ready),
      .rx_overrun     (rx_overrun),
      .rx_overrun_clr (rx_overrun_clr),
      .rx_busy        (rx_busy)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the entry the rules say this frame must produce, then drive it.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic two,
                             input logic pbit, input logic s1, input logic s2);
      logic perr, ferr;
      int   ones;
      rx_ctrl  = mode;
      rx_stop2 = two;
      ones = $countones(d) + (pbit ? 1 : 0);
      case (mode)
         2'b01:   perr = (ones % 2) != 1;
         2'b10:   perr = (ones % 2) != 0;
         2'b11:   perr = !pbit;
         default: perr = 1'b0;
      endcase
      ferr = !s1 || (two && !s2);
      if (!rx_ready && exp_q.size() >= DEPTH) exp_ovr = 1'b1;
      else exp_q.push_back({ferr, perr, d});
      frame_start = cyc;
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) hold(d[i], BIT);
      if (mode != 2'b00) hold(pbit, BIT);
      hold(s1, BIT);
      if (two) hold(s2, BIT);
      rx = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (rx_data_valid && !prev_valid) valid_rise = cyc;
            prev_valid = rx_data_valid;
            if (rx_data_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_entry: got %0h expected none", {rx_err, rx_data});
               end else begin
                  check("head", {22'd0, rx_err, rx_data}, {22'd0, exp_q[0]});
                  if (rx_ready) begin
                     last_pop = {rx_err, rx_data};
                     void'(exp_q.pop_front());
                     pops++;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      #1;
      hold(1'b1, 3);
      check("rst_data", {24'd0, rx_data}, 32'h0);
      check("rst_err", {30'd0, rx_err}, 32'h0);
      check("rst_valid", {31'd0, rx_data_valid}, 32'h0);
      check("rst_ovr", {31'd0, rx_overrun}, 32'h0);
      check("rst_busy", {31'd0, rx_busy}, 32'h0);
      rst = 1'b0;
      hold(1'b1, 5);

      p0 = pops;
      send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(1'b1, 5);
      check("none_55", {22'd0, last_pop}, 32'h055);
      check("none_pops", pops - p0, 1);
      check("latency", valid_rise - frame_start, LAT);

      send_frame(8'h55, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
      hold(1'b1, 5);
      check("odd_ok", {22'd0, last_pop}, 32'h055);
      send_frame(8'h55, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(1'b1, 5);
      check("odd_bad", {22'd0, last_pop}, 32'h155);

      send_frame(8'h33, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
      hold(1'b1, 5);
      check("even_stop2", {22'd0, last_pop}, 32'h233);

      send_frame(8'h3C, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
      hold(1'b1, 5);
      check("mark_ok", {22'd0, last_pop}, 32'h03C);
      send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(1'b1, 5);
      check("mark_bad", {22'd0, last_pop}, 32'h13C);

      rx_ready = 1'b0;
      p0 = pops;
      for (int k = 0; k < 6; k++) begin
         send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 3) begin
            check("ovr_after4", {31'd0, rx_overrun}, {31'd0, exp_ovr});
            check("valid_held", {31'd0, rx_data_valid}, 32'h1);
         end
         if (k == 4) check("ovr_after5", {31'd0, rx_overrun}, {31'd0, exp_ovr});
      end
      hold(1'b1, 5);
      rx_ready = 1'b1;
      hold(1'b1, 10);
      check("drain_count", pops - p0, 4);
      check("drain_empty", {31'd0, rx_data_valid}, 32'h0);
      check("ovr_sticky", {31'd0, rx_overrun}, 32'h1);
      rx_overrun_clr = 1'b1;
      exp_ovr = 1'b0;
      hold(1'b1, 1);
      rx_overrun_clr = 1'b0;
      check("ovr_clr", {31'd0, rx_overrun}, {31'd0, exp_ovr});

      p0 = pops;
      hold(1'b0, 3);
      hold(1'b1, 1);
      check("false_busy", {31'd0, rx_busy}, 32'h1);
      hold(1'b1, 12);
      check("false_idle", {31'd0, rx_busy}, 32'h0);
      check("false_nopush", pops - p0, 0);

      rx_ctrl = 2'b00;
      rx_stop2 = 1'b0;
      hold(1'b0, BIT * 4 + 5);
      rst = 1'b1;
      hold(1'b1, 2);
      check("mid_rst_busy", {31'd0, rx_busy}, 32'h0);
      check("mid_rst_valid", {31'd0, rx_data_valid}, 32'h0);
      rst = 1'b0;
      hold(1'b1, 5);
      p0 = pops;
      send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(1'b1, 5);
      check("after_rst", {22'd0, last_pop}, 32'h00F);
      check("after_rst_pops", pops - p0, 1);
      check("model_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the single-byte UART receiver. Adds configurable data width, parity mode, stop-bit count, framing/parity error reporting and an output FIFO with a valid/ready handshake. Sits between the board RX pin and the core's MMIO UART peripheral. Back-to-back frames are no longer lost while software is slow to read.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BODE_RATE, 115_200, line bit rate. CLKS_PER_BIT = CLK_FREQ/BODE_RATE, integer division, must be ≥4.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx  in  1  asynchronous serial line; idle high
- rx_ctrl  in  2  parity mode: 00 none, 01 odd, 10 even, 11 mark (parity bit must be 1)
- rx_stop2  in  1  1 = two stop bits are checked
- rx_data  out  DATA_BITS  FIFO head payload, LSB first on the wire
- rx_err  out  2  FIFO head flags: [0] parity error, [1] framing error
- rx_data_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts the head when rx_data_valid & rx_ready
- rx_overrun  out  1  sticky; set when a frame completes while the FIFO is full
- rx_overrun_clr  in  1  clears rx_overrun
- rx_busy  out  1  deserialiser not in IDLE

Behaviour:
- Reset is synchronous, active-high, and applies to every register. It aborts any frame in progress, flushes the FIFO, sets state to IDLE and loads the synchroniser with 1.
- Output reset values: rx_data=0, rx_err=0, rx_data_valid=0, rx_overrun=0, rx_busy=0.
- rx passes through a 2-FF synchroniser (rx_s) before use. All timing below is referenced to rx_s.
- Bit counter: cnt runs 0..CLKS_PER_BIT-1. A bit is sampled at cnt == CLKS_PER_BIT/2.
- State machine: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE→START on a falling edge of rx_s; cnt cleared.
  - START: if the mid-bit sample is 1, the start is false and the block returns to IDLE with nothing pushed. If it is 0, go to DATA at the end of the bit.
  - DATA: shift DATA_BITS samples LSB first. Then go to PARITY if rx_ctrl≠00, otherwise STOP1.
  - PARITY: the sample is compared against the expected value, giving perr. Odd mode: XOR of data and parity bit must be 1. Even mode: that XOR must be 0. Mark mode: the parity bit must be 1.
  - STOP1: the mid-bit sample must be 1; otherwise ferr. If rx_stop2 is set, go to STOP2; otherwise push and return to IDLE.
  - STOP2: same check as STOP1, then push.
  - Push and return to IDLE happen at the mid-sample of the last stop bit, not at the end of the bit. This lets back-to-back frames resynchronise on the next start edge.
- rx_ctrl and rx_stop2 are latched at the START→DATA transition. Changes during a frame take effect from the next frame.
- Pushed entry is {ferr, perr, data}. A frame with errors is still pushed.
- FIFO:
  - Head is registered and visible the cycle after the push into an empty FIFO, so mid-sample to rx_data_valid=1 is 1 clk.
  - Pop occurs on rx_data_valid & rx_ready.
  - Push and pop in the same cycle are both performed when the FIFO is full; occupancy is unchanged.
  - Push when full with no pop: the frame is dropped and rx_overrun is set the next cycle.
  - rx_overrun_clr together with a new overrun leaves the flag set.
  - Pointers wrap modulo FIFO_DEPTH. The count register is $clog2(FIFO_DEPTH)+1 bits wide.
- rx_data and rx_err remain stable while rx_data_valid & !rx_ready.

Optional Feature:
- UART_RX_MAJORITY_EN:
  - Defined: each bit value is the 2-of-3 majority of samples taken at cnt = mid-1, mid and mid+1. A single-cycle glitch at mid is rejected.
  - Undefined: the single sample at mid is used. Mid-1/mid+1 logic is not synthesised.

Decomposition:
- Package uart_pkg holds:
  - rx_ctrl encodings PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK;
  - the state enum;
  - the error-bit indices ERR_PARITY and ERR_FRAME.
- Sub-module sync_fifo (parametrised WIDTH and DEPTH, valid/ready output, full/empty flags) is instantiated once with WIDTH = DATA_BITS+2.

Test Plan (CLK_FREQ=100M, BODE_RATE=10M, bit = 10 clk = 100 ns):
- rx_ctrl=00, DATA_BITS=8, frame 0x55, rx_ready=1 → rx_data_valid pulses one cycle with rx_data=0x55 and rx_err=00.
- rx_ctrl=01, data 0x55 (four ones), parity bit 1 → rx_err=00. Repeat with parity bit 0 → 0x55 is delivered with rx_err=01.
- rx_ctrl=10, rx_stop2=1, data 0x33, second stop bit driven 0 → rx_data=0x33, rx_err=10.
- rx_ready=0, six back-to-back 0xA5 frames, FIFO_DEPTH=4 → four entries are held; rx_overrun=1 after frame 5. Raising rx_ready then drains exactly four 0xA5 entries. rx_overrun_clr then returns it to 0.
- A 3-clk low pulse on rx in IDLE → false start; no push, rx_busy returns to 0.
- rst asserted mid-frame (DATA bit 3), then a clean frame 0x0F → no partial entry; only 0x0F is received.
